motoro3_hall_decoder: RTL and testbench

- Feedback-side counterpart of the 3-phase step/commutation chain.
- Samples the three Hall sensor lines from the motor, then synchronises and debounces them.
- Decodes the 6-step sector into the same 4-bit step code the driver side uses, and infers rotation direction.
- Measures the step period at the 10 MHz clock and flags invalid codes, skipped sectors and stalls, for closed-loop control and diagnostics.

---
 rtl/motoro3_pkg.sv | 42 ++++
 rtl/motoro3_hall_debounce.sv | 55 +++++
 rtl/motoro3_hall_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_motoro3_hall_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// Shared definitions for the 3-phase commutation chain: step codes, state enum,
// Hall-to-step mapping and mod-6 step helpers.
package motoro3_pkg;

  localparam logic [3:0] STEP0        = 4'd0;
  localparam logic [3:0] STEP1        = 4'd1;
  localparam logic [3:0] STEP2        = 4'd2;
  localparam logic [3:0] STEP3        = 4'd3;
  localparam logic [3:0] STEP4        = 4'd4;
  localparam logic [3:0] STEP5        = 4'd5;
  localparam logic [3:0] STEP_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    RUN  = 2'd2
  } hall_state_e;

  // ABC Hall code to commutation step; 000 and 111 are not sectors
  function automatic logic [3:0] hall_to_step(input logic [2:0] code);
    logic [3:0] step;
    case (code)
      3'b101:  step = STEP0;
      3'b100:  step = STEP1;
      3'b110:  step = STEP2;
      3'b010:  step = STEP3;
      3'b011:  step = STEP4;
      3'b001:  step = STEP5;
      default: step = STEP_INVALID;
    endcase
    return step;
  endfunction

  function automatic logic [3:0] step_inc(input logic [3:0] step);
    return (step >= STEP5) ? STEP0 : step + 4'd1;
  endfunction

  function automatic logic [3:0] step_dec(input logic [3:0] step);
    return (step == STEP0 || step > STEP5) ? STEP5 : step - 4'd1;
  endfunction

endpackage

// File: rtl/motoro3_hall_debounce.sv
// Two-flop synchroniser and debounce for the 3-bit Hall code; the accept strobe
// fires on the edge that takes in the DEBOUNCE_CYC-th stable synchronised sample.
module motoro3_hall_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [2:0] i_code,
  output logic [2:0] o_code_c,
  output logic       o_accept_c
);

  localparam int unsigned      CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_CYC);

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_cand;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_same;

  assign w_same = (r_sync2 == r_cand);

  // Run length of the current synchronised code, saturating at the target
  always_comb begin
    w_cnt_n = CNT_W'(1);
    if (w_same) begin
      w_cnt_n = (r_cnt == CNT_TGT) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  assign o_accept_c = (w_cnt_n == CNT_TGT) && (r_sync2 != r_code);
  assign o_code_c   = o_accept_c ? r_sync2 : r_code;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_cand  <= 3'b000;
      r_code  <= 3'b000;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_code;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_cnt   <= w_cnt_n;
      if (o_accept_c) begin
        r_code <= r_sync2;
      end
    end
  end

endmodule

// File: rtl/motoro3_hall_decoder.sv
// Hall sensor decoder: sector, direction, step period, error and stall detection.
// MOTORO3_HALL_REV_PERIOD_EN: report the sum of the last six step periods instead.
module motoro3_hall_decoder
  import motoro3_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned PERIOD_W     = 25,
  parameter int unsigned STALL_CYC    = 10_000_000
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                hallA,
  input  logic                hallB,
  input  logic                hallC,
  output logic [3:0]          hallStep,
  output logic                hallValid,
  output logic                hallDir,
  output logic                hallDirValid,
  output logic                hallStepPulse,
  output logic [PERIOD_W-1:0] hallPeriod,
  output logic                hallErr,
  output logic                hallStall
);

  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
  localparam logic [PERIOD_W-1:0] STALL_LIM  = PERIOD_W'(STALL_CYC - 1);

  hall_state_e         r_state, w_state_n;
  logic [3:0]          r_step, w_step_n;
  logic                r_valid, w_valid_n;
  logic                r_dir, w_dir_n;
  logic                r_dirv, w_dirv_n;
  logic                r_pulse, w_pulse_n;
  logic                r_err, w_err_n;
  logic                r_stall, w_stall_n;
  logic [PERIOD_W-1:0] r_period, w_period_n;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_n;

  logic [2:0]          w_code;
  logic                w_accept;
  logic [3:0]          w_step_new;
  logic                w_legal;
  logic                w_fwd;
  logic                w_rev;
  logic                w_stall_evt;
  logic [PERIOD_W-1:0] w_cnt_inc;

  motoro3_hall_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk        (clk),
    .nRst       (nRst),
    .i_code     ({hallA, hallB, hallC}),
    .o_code_c   (w_code),
    .o_accept_c (w_accept)
  );

  assign w_step_new  = hall_to_step(w_code);
  assign w_legal     = (w_step_new != STEP_INVALID);
  assign w_fwd       = (w_step_new == step_inc(r_step));
  assign w_rev       = (w_step_new == step_dec(r_step));
  assign w_cnt_inc   = (r_cnt == PERIOD_MAX) ? r_cnt : r_cnt + PERIOD_W'(1);
  // An accept on the threshold edge suppresses the stall
  assign w_stall_evt = !w_accept && (r_state != IDLE) && (r_cnt == STALL_LIM);

`ifdef MOTORO3_HALL_REV_PERIOD_EN
  localparam int unsigned SUM_W = PERIOD_W + 3;

  logic [PERIOD_W-1:0] r_ring [6];
  logic [2:0]          r_fill;
  logic [2:0]          r_wr;
  logic                w_push;
  logic                w_clr;
  logic [SUM_W-1:0]    w_sum;
  logic [PERIOD_W-1:0] w_rev_sum_c;

  // Revolution sum: new period plus the five entries that survive the overwrite
  always_comb begin
    w_push = w_accept && w_legal && (r_state != IDLE) && (w_fwd || w_rev);
    w_clr  = (w_accept && !w_push) || w_stall_evt;
    w_sum  = SUM_W'(w_cnt_inc);
    for (int i = 0; i < 6; i++) begin
      if (3'(i) != r_wr) begin
        w_sum = w_sum + SUM_W'(r_ring[i]);
      end
    end
    if (r_fill < 3'd5) begin
      w_rev_sum_c = '0;
    end else if (w_sum > SUM_W'(PERIOD_MAX)) begin
      w_rev_sum_c = PERIOD_MAX;
    end else begin
      w_rev_sum_c = PERIOD_W'(w_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst || w_clr) begin
      for (int i = 0; i < 6; i++) begin
        r_ring[i] <= '0;
      end
      r_fill <= 3'd0;
      r_wr   <= 3'd0;
    end else if (w_push) begin
      r_ring[r_wr] <= w_cnt_inc;
      r_wr         <= (r_wr == 3'd5) ? 3'd0 : r_wr + 3'd1;
      r_fill       <= (r_fill == 3'd6) ? r_fill : r_fill + 3'd1;
    end
  end
`endif

  // Next-state and output logic
  always_comb begin
    w_state_n  = r_state;
    w_step_n   = r_step;
    w_valid_n  = r_valid;
    w_dir_n    = r_dir;
    w_dirv_n   = r_dirv;
    w_pulse_n  = 1'b0;
    w_err_n    = 1'b0;
    w_stall_n  = r_stall;
    w_period_n = r_period;
    w_cnt_n    = (r_state == IDLE) ? '0 : w_cnt_inc;

    if (w_accept) begin
      w_stall_n = 1'b0;
      if (!w_legal) begin
        w_err_n   = 1'b1;
        w_step_n  = STEP_INVALID;
        w_valid_n = 1'b0;
        w_dirv_n  = 1'b0;
        w_state_n = IDLE;
        w_cnt_n   = '0;
`ifdef MOTORO3_HALL_REV_PERIOD_EN
        w_period_n = '0;
`endif
      end else if (r_state == IDLE) begin
        w_state_n = LOCK;
        w_step_n  = w_step_new;
        w_valid_n = 1'b1;
        w_cnt_n   = '0;
`ifdef MOTORO3_HALL_REV_PERIOD_EN
        w_period_n = '0;
`endif
      end else begin
        w_step_n  = w_step_new;
        w_pulse_n = 1'b1;
        w_cnt_n   = '0;
`ifdef MOTORO3_HALL_REV_PERIOD_EN
        w_period_n = (w_fwd || w_rev) ? w_rev_sum_c : '0;
`else
        w_period_n = w_cnt_inc;
`endif
        if (w_fwd || w_rev) begin
          w_state_n = RUN;
          w_dir_n   = w_fwd;
          w_dirv_n  = 1'b1;
        end else begin
          w_err_n   = 1'b1;
          w_state_n = LOCK;
          w_dirv_n  = 1'b0;
        end
      end
    end else if (w_stall_evt) begin
      w_stall_n  = 1'b1;
      w_period_n = PERIOD_MAX;
      w_state_n  = LOCK;
      w_dirv_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state  <= IDLE;
      r_step   <= STEP_INVALID;
      r_valid  <= 1'b0;
      r_dir    <= 1'b0;
      r_dirv   <= 1'b0;
      r_pulse  <= 1'b0;
      r_err    <= 1'b0;
      r_stall  <= 1'b0;
      r_period <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_step   <= w_step_n;
      r_valid  <= w_valid_n;
      r_dir    <= w_dir_n;
      r_dirv   <= w_dirv_n;
      r_pulse  <= w_pulse_n;
      r_err    <= w_err_n;
      r_stall  <= w_stall_n;
      r_period <= w_period_n;
      r_cnt    <= w_cnt_n;
    end
  end

  assign hallStep      = r_step;
  assign hallValid     = r_valid;
  assign hallDir       = r_dir;
  assign hallDirValid  = r_dirv;
  assign hallStepPulse = r_pulse;
  assign hallPeriod    = r_period;
  assign hallErr       = r_err;
  assign hallStall     = r_stall;

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
// Self-checking bench for motoro3_hall_decoder: directed plus random Hall
// sequences compared every cycle with a timestamp-based reference model.
module tb_motoro3_hall_decoder;

  localparam int unsigned DEB   = 16;
  localparam int unsigned PW    = 25;
  localparam int unsigned STALL = 5000;
  localparam longint      PMAX  = (64'd1 << PW) - 1;

  logic          clk = 1'b0;
  logic          nRst;
  logic          hallA, hallB, hallC;
  logic [3:0]    hallStep;
  logic          hallValid, hallDir, hallDirValid, hallStepPulse, hallErr, hallStall;
  logic [PW-1:0] hallPeriod;

  always #50 clk = ~clk;

  motoro3_hall_decoder #(
    .DEBOUNCE_CYC (DEB),
    .PERIOD_W     (PW),
    .STALL_CYC    (STALL)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .hallA         (hallA),
    .hallB         (hallB),
    .hallC         (hallC),
    .hallStep      (hallStep),
    .hallValid     (hallValid),
    .hallDir       (hallDir),
    .hallDirValid  (hallDirValid),
    .hallStepPulse (hallStepPulse),
    .hallPeriod    (hallPeriod),
    .hallErr       (hallErr),
    .hallStall     (hallStall)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] step_code [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  // Reference model: mode 0 = no sector, 1 = sector known, 2 = running
  int         m_mode, m_step, m_run;
  logic       m_dir, m_stall, m_pulse, m_err;
  longint     m_period, m_now, m_tclr;
  logic [2:0] m_acc_code, m_pin_prev;
  logic       d0_v, d1_v;
  logic [2:0] d0_c, d1_c;
  longint     m_hist [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_step(input logic [2:0] c);
    case (c)
      3'b101:  return 0;
      3'b100:  return 1;
      3'b110:  return 2;
      3'b010:  return 3;
      3'b011:  return 4;
      3'b001:  return 5;
      default: return -1;
    endcase
  endfunction

  function automatic longint sat(input longint v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  task automatic hist_push(input longint p);
    longint s;
    m_hist.push_back(p);
    if (m_hist.size() > 6) void'(m_hist.pop_front());
    s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    m_period = (m_hist.size() == 6) ? sat(s) : 0;
  endtask

  // Apply one rising edge to the model given the inputs the DUT will sample
  task automatic model_edge(input logic rv, input logic [2:0] pins);
    logic       use_v;
    logic [2:0] use_c;
    longint     el, per;
    int         s, d;
    m_pulse = 1'b0;
    m_err   = 1'b0;
    if (!rv) begin
      m_mode = 0; m_step = -1; m_dir = 1'b0; m_stall = 1'b0; m_period = 0;
      m_now = 0; m_tclr = 0; m_acc_code = 3'b000; m_run = 0;
      d0_v = 1'b0; d1_v = 1'b0; m_hist.delete();
      return;
    end
    m_now++;
    if (m_run > 0 && pins == m_pin_prev) begin
      if (m_run < 1000000) m_run++;
    end else begin
      m_run = 1;
    end
    m_pin_prev = pins;
    // A code held DEB samples is taken in two edges later (synchroniser delay)
    use_v = d1_v; use_c = d1_c;
    d1_v  = d0_v; d1_c  = d0_c;
    d0_v  = (m_run == DEB) && (pins != m_acc_code);
    d0_c  = pins;
    el = m_now - m_tclr;
    if (use_v) begin
      m_acc_code = use_c;
      m_stall    = 1'b0;
      s = code_step(use_c);
      if (s < 0) begin
        m_err = 1'b1; m_step = -1; m_mode = 0; m_tclr = m_now;
`ifdef MOTORO3_HALL_REV_PERIOD_EN
        m_hist.delete(); m_period = 0;
`endif
      end else if (m_mode == 0) begin
        m_mode = 1; m_step = s; m_tclr = m_now;
`ifdef MOTORO3_HALL_REV_PERIOD_EN
        m_hist.delete(); m_period = 0;
`endif
      end else begin
        d = (s - m_step + 6) % 6;
        per = sat(el);
        m_pulse = 1'b1;
        m_tclr = m_now;
        if (d == 1 || d == 5) begin
          m_mode = 2;
          m_dir  = (d == 1);
`ifdef MOTORO3_HALL_REV_PERIOD_EN
          hist_push(per);
`else
          m_period = per;
`endif
        end else begin
          m_err  = 1'b1;
          m_mode = 1;
`ifdef MOTORO3_HALL_REV_PERIOD_EN
          m_hist.delete(); m_period = 0;
`else
          m_period = per;
`endif
        end
        m_step = s;
      end
    end else if (m_mode != 0 && el == STALL) begin
      m_stall = 1'b1; m_period = PMAX; m_mode = 1; m_hist.delete();
    end
  endtask

  task automatic check_all();
    check_eq("step",      32'(hallStep),      (m_step < 0) ? 32'hF : 32'(m_step));
    check_eq("valid",     32'(hallValid),     32'(m_step >= 0));
    check_eq("dir",       32'(hallDir),       32'(m_dir));
    check_eq("dir_valid", 32'(hallDirValid),  32'(m_mode == 2));
    check_eq("pulse",     32'(hallStepPulse), 32'(m_pulse));
    check_eq("period",    32'(hallPeriod),    32'(m_period));
    check_eq("err",       32'(hallErr),       32'(m_err));
    check_eq("stall",     32'(hallStall),     32'(m_stall));
  endtask

  task automatic cycle(input logic rv, input logic [2:0] pins);
    nRst = rv;
    {hallA, hallB, hallC} = pins;
    model_edge(rv, pins);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [2:0] pins, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, pins);
  endtask

  int          cur;
  int unsigned r, len;
  logic [2:0]  gcode;

  initial begin
    // Reset with sector 0 present, then forward, reversal and a skip
    cycle(1'b0, 3'b101);
    cycle(1'b0, 3'b101);
    hold(3'b101, 30);
    hold(3'b100, 1000);
    hold(3'b110, 1000);
    hold(3'b010, 1000);
    hold(3'b110, 1000);
    hold(3'b101, 1000);
    // Glitch rejection, then an invalid code held long enough
    hold(3'b100, 1000);
    hold(3'b000, 10);
    hold(3'b100, 500);
    hold(3'b000, 300);
    // Stall in RUN and recovery
    hold(3'b101, 200);
    hold(3'b100, 200);
    hold(3'b100, 6000);
    hold(3'b110, 500);
    // Seven forward steps of 500 cycles
    for (int i = 3; i < 10; i++) hold(step_code[i % 6], 500);
    // Debounce boundary: DEB-1 rejected, DEB accepted
    hold(3'b000, DEB - 1);
    hold(step_code[3], 200);
    hold(3'b000, DEB);
    hold(step_code[3], 200);
    // Reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b011);
    hold(3'b011, 100);
    hold(3'b001, 400);
    cur = 5;
    for (int k = 0; k < 150; k++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(DEB + 1, 400);
      if (r < 40) begin
        cur = (cur + 1) % 6;
        hold(step_code[cur], int'(len));
      end else if (r < 70) begin
        cur = (cur + 5) % 6;
        hold(step_code[cur], int'(len));
      end else if (r < 80) begin
        cur = (cur + int'($urandom_range(2, 4))) % 6;
        hold(step_code[cur], int'(len));
      end else if (r < 87) begin
        hold(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111, int'(len));
      end else begin
        gcode = 3'($urandom_range(0, 7));
        hold(gcode, int'($urandom_range(1, DEB + 1)));
        hold(step_code[cur], int'(len));
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
